// File: rtl/fpu_addsub_pipe.sv
// Three-stage floating-point adder/subtractor: align, add/sub, normalise/round/pack.
// Stream interface with a global stall: all stages hold together when the output is blocked.
module fpu_addsub_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     a,
    input  logic [EXP_W+MAN_W:0]     b,
    input  logic                     op_sub,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     result,
    output logic                     overflow_underflow_flag
);
    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int SW  = MAN_W + 4;
    localparam int LZW = $clog2(SW);
    localparam logic [EXP_W-1:0] EXP_MAX = '1;
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    logic en;
    logic out_valid_q;
    logic [W-1:0] result_q;
    logic flag_q;

    assign en        = !out_valid_q | out_ready;
    assign in_ready  = en;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign overflow_underflow_flag = flag_q;

    // ---------------- S1: decode, swap, align ----------------
    logic             sa, sb, a_nan, b_nan, a_inf, b_inf, swap;
    logic [EXP_W-1:0] ea, eb, x_exp, y_exp, diff;
    logic [MAN_W-1:0] ma, mb;
    logic [MAN_W:0]   siga, sigb, sig_x, sig_y;
    logic [SW-1:0]    ext_y, lost, aligned;
    logic             s1_special_d, s1_sign_d;
    logic [W-1:0]     s1_spec_d;

    always_comb begin
        sa    = a[W-1];
        sb    = b[W-1] ^ op_sub;
        ea    = a[W-2:MAN_W];
        eb    = b[W-2:MAN_W];
        ma    = a[MAN_W-1:0];
        mb    = b[MAN_W-1:0];
        a_nan = (ea == EXP_MAX) && (ma != '0);
        b_nan = (eb == EXP_MAX) && (mb != '0);
        a_inf = (ea == EXP_MAX) && (ma == '0);
        b_inf = (eb == EXP_MAX) && (mb == '0);
        // Zero exponent covers denormals too: they enter as exact zeros.
        siga  = (ea == '0) ? '0 : {1'b1, ma};
        sigb  = (eb == '0) ? '0 : {1'b1, mb};
        swap  = {eb, sigb} > {ea, siga};
        s1_sign_d = swap ? sb : sa;
        x_exp = swap ? eb : ea;
        y_exp = swap ? ea : eb;
        sig_x = swap ? sigb : siga;
        sig_y = swap ? siga : sigb;
        diff  = x_exp - y_exp;
        ext_y = {sig_y, 3'b000};
        lost  = '0;
        if (32'(diff) >= SW - 1) begin
            aligned = {{(SW-1){1'b0}}, |sig_y};
        end else begin
            lost       = ext_y & ~({SW{1'b1}} << diff);
            aligned    = ext_y >> diff;
            aligned[0] = aligned[0] | (|lost);
        end
        s1_special_d = a_nan | b_nan | a_inf | b_inf;
        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb)))
            s1_spec_d = QNAN;
        else if (a_inf)
            s1_spec_d = {sa, EXP_MAX, {MAN_W{1'b0}}};
        else
            s1_spec_d = {sb, EXP_MAX, {MAN_W{1'b0}}};
    end

    logic             s1_valid_q, s1_special_q, s1_sign_q, s1_zsign_q, s1_sub_q;
    logic [W-1:0]     s1_spec_q;
    logic [EXP_W-1:0] s1_exp_q;
    logic [SW-1:0]    s1_sigx_q, s1_sigy_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_special_q <= 1'b0;
            s1_sign_q    <= 1'b0;
            s1_zsign_q   <= 1'b0;
            s1_sub_q     <= 1'b0;
            s1_spec_q    <= '0;
            s1_exp_q     <= '0;
            s1_sigx_q    <= '0;
            s1_sigy_q    <= '0;
        end else if (en) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_special_q <= s1_special_d;
                s1_sign_q    <= s1_sign_d;
                s1_zsign_q   <= sa & sb;
                s1_sub_q     <= sa ^ sb;
                s1_spec_q    <= s1_spec_d;
                s1_exp_q     <= x_exp;
                s1_sigx_q    <= {sig_x, 3'b000};
                s1_sigy_q    <= aligned;
            end
        end
    end

    // ---------------- S2: significand add/sub ----------------
    logic [SW:0] s2_sum_d;
    assign s2_sum_d = s1_sub_q ? ({1'b0, s1_sigx_q} - {1'b0, s1_sigy_q})
                               : ({1'b0, s1_sigx_q} + {1'b0, s1_sigy_q});

    logic             s2_valid_q, s2_special_q, s2_sign_q, s2_zsign_q;
    logic [W-1:0]     s2_spec_q;
    logic [EXP_W-1:0] s2_exp_q;
    logic [SW:0]      s2_sum_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q   <= 1'b0;
            s2_special_q <= 1'b0;
            s2_sign_q    <= 1'b0;
            s2_zsign_q   <= 1'b0;
            s2_spec_q    <= '0;
            s2_exp_q     <= '0;
            s2_sum_q     <= '0;
        end else if (en) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_special_q <= s1_special_q;
                s2_sign_q    <= s1_sign_q;
                s2_zsign_q   <= s1_zsign_q;
                s2_spec_q    <= s1_spec_q;
                s2_exp_q     <= s1_exp_q;
                s2_sum_q     <= s2_sum_d;
            end
        end
    end

    // ---------------- S3: normalise, round, pack ----------------
    logic [LZW-1:0]   lzc;
    logic [SW-1:0]    norm;
    logic [MAN_W+1:0] rnd;
    logic [MAN_W-1:0] man_r;
    logic             round_up;
    int               exp_n;
    logic [W-1:0]     res_d;
    logic             flag_d;

    always_comb begin
        lzc = '0;
        for (int i = 0; i < SW; i++)
            if (s2_sum_q[i]) lzc = LZW'(SW - 1 - i);
        if (s2_sum_q[SW]) begin
            norm  = {s2_sum_q[SW:2], s2_sum_q[1] | s2_sum_q[0]};
            exp_n = int'(s2_exp_q) + 1;
        end else begin
            norm  = s2_sum_q[SW-1:0] << lzc;
            exp_n = int'(s2_exp_q) - int'(lzc);
        end
        // Guard set and (round|sticky|lsb) set: nearest, ties to even.
        round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
        rnd      = {1'b0, norm[SW-1:3]} + {{(MAN_W+1){1'b0}}, round_up};
        if (rnd[MAN_W+1]) begin
            man_r = rnd[MAN_W:1];
            exp_n = exp_n + 1;
        end else begin
            man_r = rnd[MAN_W-1:0];
        end
        flag_d = 1'b0;
        if (s2_special_q) begin
            res_d = s2_spec_q;
        end else if (s2_sum_q == '0) begin
            res_d = {s2_zsign_q, {(W-1){1'b0}}};
        end else if (exp_n >= int'(EXP_MAX)) begin
            res_d  = {s2_sign_q, EXP_MAX, {MAN_W{1'b0}}};
            flag_d = 1'b1;
        end else if (exp_n <= 0) begin
            res_d  = {s2_sign_q, {(W-1){1'b0}}};
            flag_d = 1'b1;
        end else begin
            res_d = {s2_sign_q, EXP_W'(exp_n), man_r};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flag_q      <= 1'b0;
        end else if (en) begin
            out_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                result_q <= res_d;
                flag_q   <= flag_d;
            end
        end
    end

endmodule

// File: tb/tb_fpu_addsub_pipe.sv
// Directed bench for fpu_addsub_pipe (single precision): arithmetic, rounding, specials,
// backpressure and asynchronous reset with beats in flight.
module tb_fpu_addsub_pipe;
    logic        clk, rst, in_valid, in_ready, op_sub, out_valid, out_ready, flag;
    logic [31:0] a, b, result;
    int          n_cmp = 0;
    int          n_err = 0;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
        logic [31:0] res;
        logic        flag;
    } vec_t;

    fpu_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op_sub(op_sub), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .overflow_underflow_flag(flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic run_one(input logic [31:0] va, input logic [31:0] vb, input logic vop,
                           output logic [31:0] res, output logic flg, output int lat);
        @(negedge clk);
        a = va; b = vb; op_sub = vop; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        res = result;
        flg = flag;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; op_sub = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
        n_cmp++; if (result !== 32'h0) begin n_err++; $display("FAIL reset result: got %h want 00000000", result); end
        n_cmp++; if (flag !== 1'b0) begin n_err++; $display("FAIL reset flag: got %b want 0", flag); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
        rst = 1'b0;
        $display("reset: out_valid=%b result=%h flag=%b in_ready=%b", out_valid, result, flag, in_ready);
    endtask

    task automatic test_vectors(input string name, input vec_t v [4], input int n);
        logic [31:0] res;
        logic        flg;
        int          lat;
        for (int i = 0; i < n; i++) begin
            run_one(v[i].a, v[i].b, v[i].op, res, flg, lat);
            $display("%s[%0d]: %h %s %h -> %h flag=%b lat=%0d", name, i, v[i].a,
                     v[i].op ? "-" : "+", v[i].b, res, flg, lat);
            n_cmp++; if (res !== v[i].res) begin n_err++; $display("FAIL %s[%0d] result: got %h want %h", name, i, res, v[i].res); end
            n_cmp++; if (flg !== v[i].flag) begin n_err++; $display("FAIL %s[%0d] flag: got %b want %b", name, i, flg, v[i].flag); end
            n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL %s[%0d] latency: got %0d want 3", name, i, lat); end
        end
    endtask

    task automatic test_basic();
        vec_t v [4];
        v[0] = '{32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 1'b0};
        v[1] = '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0};
        v[2] = '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 1'b0};
        v[3] = '{32'hC0000000, 32'h3F800000, 1'b0, 32'hBF800000, 1'b0};
        test_vectors("basic", v, 4);
    endtask

    task automatic test_rounding();
        vec_t v [4];
        v[0] = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 1'b0};
        v[1] = '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 1'b0};
        v[2] = '{32'h4B7FFFFF, 32'h3F000000, 1'b0, 32'h4B800000, 1'b0};
        v[3] = '{32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 1'b0};
        test_vectors("round", v, 4);
    endtask

    task automatic test_flags();
        vec_t v [4];
        v[0] = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1};
        v[1] = '{32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 1'b1};
        v[2] = '{32'h40000000, 32'h40000000, 1'b1, 32'h00000000, 1'b0};
        v[3] = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 1'b0};
        test_vectors("flags", v, 4);
    endtask

    task automatic test_specials();
        vec_t v [4];
        v[0] = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 1'b0};
        v[1] = '{32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 1'b0};
        v[2] = '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 1'b0};
        v[3] = '{32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 1'b0};
        test_vectors("special", v, 4);
    endtask

    task automatic test_back_to_back();
        logic [31:0] op_a [5];
        logic [31:0] exp_r [5];
        logic [31:0] held;
        int          sent, got, stall, extra;
        logic        seen;
        op_a  = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};
        exp_r = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000};
        sent = 0; got = 0; stall = 0; seen = 1'b0; held = '0;
        for (int cyc = 0; cyc < 60 && got < 5; cyc++) begin
            @(negedge clk);
            if (out_valid && !seen) begin seen = 1'b1; stall = 4; held = result; end
            if (stall > 0) begin
                out_ready = 1'b0;
                n_cmp++;
                if (out_valid !== 1'b1 || result !== held) begin
                    n_err++; $display("FAIL bp stall hold: got v=%b %h want v=1 %h", out_valid, result, held);
                end
            end else begin
                out_ready = 1'b1;
            end
            if (sent < 5) begin
                in_valid = 1'b1; a = op_a[sent]; b = 32'h3F800000; op_sub = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            n_cmp++;
            if (in_ready !== (stall == 0)) begin
                n_err++; $display("FAIL bp in_ready cyc %0d: got %b want %b", cyc, in_ready, stall == 0);
            end
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                $display("bp[%0d]: result=%h", got, result);
                n_cmp++;
                if (result !== exp_r[got]) begin
                    n_err++; $display("FAIL bp order[%0d]: got %h want %h", got, result, exp_r[got]);
                end
                got++;
            end
            if (stall > 0) stall--;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_cmp++; if (got !== 5) begin n_err++; $display("FAIL bp count: got %0d results want 5", got); end
        extra = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        n_cmp++; if (extra !== 0) begin n_err++; $display("FAIL bp duplicate: got %0d extra beats want 0", extra); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] res;
        logic        flg;
        int          lat, stale;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a = 32'h3F800000; b = 32'h3F800000; op_sub = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rstmid in flight: got out_valid %b want 1", out_valid); end
        #2 rst = 1'b1;
        #1;
        $display("rstmid: async reset out_valid=%b result=%h flag=%b", out_valid, result, flag);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid out_valid: got %b want 0", out_valid); end
        n_cmp++; if (result !== 32'h0) begin n_err++; $display("FAIL rstmid result: got %h want 00000000", result); end
        n_cmp++; if (flag !== 1'b0) begin n_err++; $display("FAIL rstmid flag: got %b want 0", flag); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        n_cmp++; if (stale !== 0) begin n_err++; $display("FAIL rstmid stale: got %0d beats want 0", stale); end
        run_one(32'h40000000, 32'h3F800000, 1'b1, res, flg, lat);
        $display("rstmid: 40000000 - 3F800000 -> %h lat=%0d", res, lat);
        n_cmp++; if (res !== 32'h3F800000) begin n_err++; $display("FAIL rstmid post result: got %h want 3F800000", res); end
        n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL rstmid post latency: got %0d want 3", lat); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_flags();
        test_specials();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fpu_addsub_pipe.md
Name: fpu_addsub_pipe

Overview:
- Parametrised, pipelined IEEE-754-style floating-point adder/subtractor.
- Successor to the combinational single-precision subtractor. Adds generic exponent/mantissa widths, a runtime add/sub select, round-to-nearest-even, special-value handling and a valid/ready stream interface.
- Fixed latency of 3 cycles. Sits between operand-issue logic and the FPU result bus.

Parameters:
EXP_W, 8, exponent field width (bias = 2^(EXP_W-1)-1)
MAN_W, 23, stored mantissa width (hidden bit implicit); W = 1+EXP_W+MAN_W

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  operand beat valid
in_ready  out  1  block accepts beat this cycle
a  in  W  operand A
b  in  W  operand B
op_sub  in  1  0: a+b, 1: a-b
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
result  out  W  rounded result
overflow_underflow_flag  out  1  result overflowed to ±inf or underflowed to ±0

Behaviour:
- Reset (async, active-high): all stage valid bits = 0, out_valid = 0, result = 0, overflow_underflow_flag = 0.
- Pipeline advance enable: en = !out_valid | out_ready. in_ready = en (combinational).
- A beat is accepted when in_valid & in_ready. When en = 0, all stages hold: no bubble collapse, no data loss.
- Latency: an accepted beat appears on out_valid exactly 3 cycles later, provided en stays 1. Sustained throughput is 1 beat/cycle.
- S1, align:
  - Effective sign of b = b.sign ^ op_sub.
  - Swap so the larger magnitude (exponent, then mantissa) is operand X.
  - Right-shift the smaller significand by the exponent difference into a field extended with guard, round and sticky bits. Sticky ORs every bit shifted out.
  - A shift ≥ MAN_W+3 leaves the sticky bit only.
- S2, add/sub: add or subtract the significands (MAN_W+4 bits plus carry). The result sign is the sign of X.
- S3, normalise/round/pack:
  - On carry-out, shift right 1 (sticky absorbs the lost bit) and exp+1.
  - Otherwise, left-shift by the leading-zero count and reduce the exponent accordingly.
  - Round to nearest, ties to even. A rounding carry renormalises.
- Exponent rules:
  - Biased exponent ≥ 2^EXP_W-1 after rounding: result = ±inf, flag = 1.
  - Biased exponent ≤ 0 with a nonzero significand: result = ±0 (flush to zero), flag = 1.
  - Otherwise flag = 0.
- Exact cancellation (x - x) gives +0, flag = 0.
- Signed zeros: (-0) + (-0) = -0; any other zero sum = +0.
- Inputs with exponent = 0 are treated as ±0 (denormals flushed on input). This does not set the flag.
- Specials are resolved in S1 and carried as a bypass through S2/S3, with flag = 0:
  - Any NaN operand gives canonical qNaN (exp all 1s, mantissa MSB 1, sign 0).
  - inf - inf (effective) gives canonical qNaN.
  - inf ± finite gives the inf with its effective sign.
- result and flag change only when a beat moves into the output register. Both hold while out_valid & !out_ready.

Test Plan:
- Basic add/sub, EXP_W=8, MAN_W=23, out_ready=1:
  - a=3F800000, b=40000000, op_sub=1 → BF800000, flag 0, out_valid exactly 3 cycles after accept.
  - Same a, b with op_sub=0 → 40400000.
- Rounding ties, op_sub=0:
  - 3F800000 + 33800000 → 3F800000.
  - 3F800001 + 33800000 → 3F800002.
  - 4B7FFFFF + 3F000000 → 4B800000 (rounding carry renormalises).
- Flag cases:
  - 7F7FFFFF + 7F7FFFFF → 7F800000, flag 1.
  - 00800001 - 00800000 → 00000000, flag 1.
  - 40000000 - 40000000 → 00000000, flag 0.
- Specials:
  - 7F800000 - 7F800000 → 7FC00000.
  - FF800000 + 3F800000 → FF800000.
  - 7FC00001 + anything → 7FC00000.
- Backpressure:
  - Stream 5 back-to-back beats, hold out_ready=0 for 4 cycles after the first out_valid.
  - in_ready must drop in the same cycles.
  - All 5 results arrive in order, none lost or duplicated, and result stays stable while stalled.
- Reset mid-operation:
  - Assert rst asynchronously with 3 beats in flight.
  - out_valid, result and flag go to 0 immediately (before the next clock edge).
  - No stale beat emerges after rst deasserts.
  - The next accepted beat has 3-cycle latency.
